// File: rtl/output_bank.sv
// Multi-channel fabric-to-pad output cell: combinational buffer, registered output with hold,
// or LSB-first parallel-to-serial shifter with a valid/ready word handshake.
module output_bank #(
    parameter int              WIDTH     = 4,
    parameter string           MODE      = "out_reg",
    parameter int              SER_RATIO = 4,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic                           IQC,
    input  logic                           QRT,
    input  logic [WIDTH*SER_RATIO-1:0]     OQI,
    input  logic                           OQI_VLD,
    output logic                           OQI_RDY,
    input  logic                           HOLD,
    output logic [WIDTH-1:0]               F2A,
    output logic                           F2A_ACT
);

    if (MODE == "out_buff") begin : g_buff
        for (genvar c = 0; c < WIDTH; c++) begin : g_tap
            assign F2A[c] = OQI[c*SER_RATIO];
        end
        assign OQI_RDY = 1'b1;
        assign F2A_ACT = 1'b0;

        logic unused_buff;
        assign unused_buff = ^{IQC, QRT, HOLD, OQI_VLD, OQI};
    end else if (MODE == "out_reg") begin : g_reg
        logic [WIDTH-1:0] tap;
        logic [WIDTH-1:0] f2a_q;

        for (genvar c = 0; c < WIDTH; c++) begin : g_tap
            assign tap[c] = OQI[c*SER_RATIO];
        end

        always_ff @(posedge IQC) begin
            if (QRT) begin
                f2a_q <= INIT;
            end else if (!HOLD) begin
                f2a_q <= tap;
            end
        end

        assign F2A     = f2a_q;
        assign OQI_RDY = ~HOLD & ~QRT;
        assign F2A_ACT = 1'b0;

        logic unused_reg;
        assign unused_reg = ^{OQI_VLD, OQI};
    end else if (MODE == "out_ser") begin : g_ser
        if (SER_RATIO < 2) begin : g_bad_ratio
            $error("output_bank: SER_RATIO must be >= 2 in out_ser mode");
        end

        localparam int             CW   = (SER_RATIO > 1) ? $clog2(SER_RATIO) : 1;
        localparam logic [CW-1:0]  LAST = CW'(SER_RATIO - 1);

        typedef enum logic {IDLE, SHIFT} state_t;

        state_t                             state;
        logic [CW-1:0]                      cnt;
        logic [WIDTH-1:0][SER_RATIO-1:0]    shreg;
        logic [WIDTH-1:0]                   f2a_q;
        logic                               rdy;
        logic                               accept;

        // Ready on the last bit too, so a waiting word follows with no idle gap.
        assign rdy    = ~QRT & ~HOLD & ((state == IDLE) | (cnt == LAST));
        assign accept = OQI_VLD & rdy;

        // Bit 0 goes straight to the pad on accept; shreg keeps the remaining bits, next one at [0].
        always_ff @(posedge IQC) begin
            if (QRT) begin
                state <= IDLE;
                cnt   <= '0;
                shreg <= '0;
                f2a_q <= INIT;
            end else if (!HOLD) begin
                if (accept) begin
                    for (int c = 0; c < WIDTH; c++) begin
                        shreg[c] <= OQI[c*SER_RATIO +: SER_RATIO] >> 1;
                        f2a_q[c] <= OQI[c*SER_RATIO];
                    end
                    cnt   <= '0;
                    state <= SHIFT;
                end else if (state == SHIFT) begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                        for (int c = 0; c < WIDTH; c++) begin
                            shreg[c] <= shreg[c] >> 1;
                            f2a_q[c] <= shreg[c][0];
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        f2a_q <= INIT;
                    end
                end
            end
        end

        assign F2A     = f2a_q;
        assign OQI_RDY = rdy;
        assign F2A_ACT = (state == SHIFT);
    end else begin : g_bad_mode
        $error("output_bank: MODE must be out_buff, out_reg or out_ser");
    end

endmodule

// File: tb/tb_output_bank.sv
// Scoreboard bench for output_bank: one instance per mode sharing control stimulus,
// predictor pushes expected pad values at each edge, monitor pops and compares mid-cycle.
module tb_output_bank;

    logic        clk = 1'b0;
    logic        qrt;
    logic        hold;
    logic        vld;
    logic [15:0] oqi16;
    logic [7:0]  oqi8;

    logic [3:0]  f2a_buff, f2a_reg;
    logic [1:0]  f2a_ser;
    logic        rdy_buff, rdy_reg, rdy_ser;
    logic        act_buff, act_reg, act_ser;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    output_bank #(.WIDTH(4), .MODE("out_buff"), .SER_RATIO(4), .INIT(4'b0000)) u_buff (
        .IQC(clk), .QRT(qrt), .OQI(oqi16), .OQI_VLD(vld), .OQI_RDY(rdy_buff),
        .HOLD(hold), .F2A(f2a_buff), .F2A_ACT(act_buff)
    );

    output_bank #(.WIDTH(4), .MODE("out_reg"), .SER_RATIO(4), .INIT(4'b1010)) u_reg (
        .IQC(clk), .QRT(qrt), .OQI(oqi16), .OQI_VLD(vld), .OQI_RDY(rdy_reg),
        .HOLD(hold), .F2A(f2a_reg), .F2A_ACT(act_reg)
    );

    output_bank #(.WIDTH(2), .MODE("out_ser"), .SER_RATIO(4), .INIT(2'b01)) u_ser (
        .IQC(clk), .QRT(qrt), .OQI(oqi8), .OQI_VLD(vld), .OQI_RDY(rdy_ser),
        .HOLD(hold), .F2A(f2a_ser), .F2A_ACT(act_ser)
    );

    function automatic logic [3:0] taps16(input logic [15:0] w);
        return {w[12], w[8], w[4], w[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic h, input logic r,
                                 input logic [15:0] w16, input logic [7:0] w8);
        @(posedge clk);
        #1;
        vld   = v;
        hold  = h;
        qrt   = r;
        oqi16 = w16;
        oqi8  = w8;
    endtask

    // Reference model: a word becomes a queue of per-cycle pad vectors, consumed one per unheld edge.
    logic [3:0] regModel = 4'b1010;
    logic [3:0] regq[$];
    logic [1:0] pend[$];
    logic [1:0] serF2a   = 2'b01;
    logic       serAct   = 1'b0;
    logic [2:0] serq[$];
    int         serAccepts = 0;

    always @(posedge clk) begin
        if (qrt) regModel = 4'b1010;
        else if (!hold) regModel = taps16(oqi16);
        regq.push_back(regModel);

        if (qrt) begin
            pend.delete();
            serF2a = 2'b01;
            serAct = 1'b0;
        end else if (!hold) begin
            if (vld && pend.size() == 0) begin
                serAccepts++;
                for (int i = 0; i < 4; i++) pend.push_back({oqi8[4+i], oqi8[i]});
            end
            if (pend.size() > 0) begin
                serF2a = pend.pop_front();
                serAct = 1'b1;
            end else begin
                serF2a = 2'b01;
                serAct = 1'b0;
            end
        end
        serq.push_back({serAct, serF2a});
    end

    int actCycles   = 0;
    int dutAccepts  = 0;

    always @(negedge clk) begin
        logic [3:0] er;
        logic [2:0] es;
        checkOutput("buff_f2a", 32'(f2a_buff), 32'(taps16(oqi16)));
        checkOutput("buff_rdy", 32'(rdy_buff), 32'd1);
        checkOutput("buff_act", 32'(act_buff), 32'd0);

        if (regq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL reg_queue: got empty expected entry");
        end else begin
            er = regq.pop_front();
            checkOutput("reg_f2a", 32'(f2a_reg), 32'(er));
        end
        checkOutput("reg_rdy", 32'(rdy_reg), 32'(!hold && !qrt));
        checkOutput("reg_act", 32'(act_reg), 32'd0);

        if (serq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ser_queue: got empty expected entry");
        end else begin
            es = serq.pop_front();
            checkOutput("ser_f2a", 32'(f2a_ser), 32'(es[1:0]));
            checkOutput("ser_act", 32'(act_ser), 32'(es[2]));
        end
        checkOutput("ser_rdy", 32'(rdy_ser), 32'(!qrt && !hold && pend.size() == 0));

        if (act_ser) actCycles++;
        if (vld && rdy_ser) dutAccepts++;
    end

    initial begin
        int a0;
        int n;
        vld = 1'b0; hold = 1'b0; qrt = 1'b1; oqi16 = '0; oqi8 = '0;

        // reset plus buffer patterns
        applyStimulus(0, 0, 1, 16'h0001, 8'h00);
        applyStimulus(0, 0, 1, 16'h1111, 8'h00);
        applyStimulus(0, 0, 0, 16'h1110, 8'h00);

        // registered mode: reset pulse, load, hold three cycles, release
        applyStimulus(0, 0, 1, 16'h0000, 8'h00);
        applyStimulus(0, 0, 0, 16'h1111, 8'h00);
        repeat (3) applyStimulus(0, 1, 0, 16'h0000, 8'h00);
        repeat (2) applyStimulus(0, 0, 0, 16'h0000, 8'h00);

        // single serial word
        applyStimulus(1, 0, 0, 16'h0000, 8'b0110_1001);
        repeat (6) applyStimulus(0, 0, 0, 16'h0000, 8'h00);

        // back-to-back words
        a0 = dutAccepts;
        n  = serAccepts;
        applyStimulus(1, 0, 0, 16'h0000, 8'hF0);
        for (int i = 0; i < 20 && serAccepts == n; i++) applyStimulus(1, 0, 0, 16'h0000, 8'hF0);
        for (int i = 0; i < 20 && serAccepts == n + 1; i++) applyStimulus(1, 0, 0, 16'h0000, 8'h0F);
        checkOutput("b2b_model_accepts", 32'(serAccepts - n), 32'd2);
        applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        repeat (6) applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        checkOutput("b2b_accepts", 32'(dutAccepts - a0), 32'd2);

        // hold mid-word at bit 1
        actCycles = 0;
        applyStimulus(1, 0, 0, 16'h0000, 8'hA5);
        applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        repeat (3) applyStimulus(0, 1, 0, 16'h0000, 8'h00);
        repeat (8) applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        checkOutput("hold_active_cycles", 32'(actCycles), 32'd7);

        // reset mid-word at bit 2, then a fresh word
        a0 = dutAccepts;
        applyStimulus(1, 0, 0, 16'h0000, 8'h3C);
        applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        applyStimulus(1, 0, 1, 16'h0000, 8'hC3);
        applyStimulus(1, 0, 0, 16'h0000, 8'hC3);
        repeat (6) applyStimulus(0, 0, 0, 16'h0000, 8'h00);
        checkOutput("rst_accepts", 32'(dutAccepts - a0), 32'd2);

        // randomized traffic
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 29) == 0),
                          16'($urandom), 8'($urandom));
        end
        repeat (8) applyStimulus(0, 0, 0, 16'h0000, 8'h00);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
